// File: rtl/robo_cmd_executor_pkg.sv
// robo_pkg: shared definitions for the command executor.
//   - command codes as produced by the path planner (3 bits)
//   - motor drive codes (2 bits, {fwd, rev})
//   - executor state enum, also exported on the debug state port
//   - follow_drive(): proportional steering map from line sensors to motors
package robo_pkg;

    localparam logic [2:0] CMD_NOP      = 3'd0;
    localparam logic [2:0] CMD_STRAIGHT = 3'd1;
    localparam logic [2:0] CMD_LEFT     = 3'd2;
    localparam logic [2:0] CMD_RIGHT    = 3'd3;
    localparam logic [2:0] CMD_UTURN    = 3'd4;

    localparam logic [1:0] MOT_FWD  = 2'b10;
    localparam logic [1:0] MOT_REV  = 2'b01;
    localparam logic [1:0] MOT_STOP = 2'b00;

    localparam int TURN_TIMER_W = 26;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PIVOT,
        ST_FOLLOW,
        ST_NEXT,
        ST_DONE,
        ST_FAULT
    } state_t;

    // Sensors are {left, centre, right}. When the line drifts to one side,
    // stopping the motor on that side swings the robot back over it. Anything
    // else (centred, gap, node crossing) drives straight ahead.
    function automatic logic [3:0] follow_drive(input logic [2:0] sens);
        case (sens)
            3'b110, 3'b100: follow_drive = {MOT_STOP, MOT_FWD};
            3'b011, 3'b001: follow_drive = {MOT_FWD, MOT_STOP};
            default:        follow_drive = {MOT_FWD, MOT_FWD};
        endcase
    endfunction

endpackage

// File: rtl/robo_cmd_executor_node_detector.sv
// node_detector: debounced node (crossing) detector.
//   clk_50    in   system clock
//   rst_n     in   synchronous active-low reset
//   line_sens in   {left, centre, right} line sensors, 1 = on line
//   node      out  one-cycle pulse after NODE_DEB consecutive 111 samples
// After a pulse the detector is disarmed until it has seen NODE_DEB
// consecutive non-111 samples, so one physical node is counted once.
module node_detector #(
    parameter int NODE_DEB = 1000
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic [2:0] line_sens,
    output logic       node
);

    localparam int              CNT_W    = $clog2(NODE_DEB + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NODE_DEB - 1);

    logic             armed;
    logic [CNT_W-1:0] cnt;
    logic             on_node;
    logic             qualify;

    assign on_node = (line_sens == 3'b111);
    // Armed: count 111 samples. Disarmed: count non-111 samples. The same
    // counter serves both phases; any opposite sample restarts it.
    assign qualify = (armed == on_node);

    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            armed <= 1'b1;
            cnt   <= '0;
            node  <= 1'b0;
        end else begin
            node <= 1'b0;
            if (qualify) begin
                if (cnt == CNT_LAST) begin
                    cnt   <= '0;
                    armed <= ~armed;
                    node  <= armed;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/robo_cmd_executor.sv
// robo_cmd_executor: walks the planner's command list and drives the motors.
//   clk_50       in   system clock
//   rst_n        in   synchronous active-low reset
//   plan_valid   in   planner holds a stable list
//   cmd_count    in   number of list entries
//   robo_command in   entry addressed by counter (combinational lookup)
//   line_sens    in   {left, centre, right} line sensors
//   counter      out  current list index
//   mot_l/mot_r  out  motor drive, 10 fwd / 01 rev / 00 stop
//   busy         out  high from FETCH through NEXT
//   fault        out  sticky pivot-timeout flag
//   state        out  current FSM state (debug)
// Handshake: the planner presents a list by raising plan_valid; the executor
// addresses entries with counter and samples robo_command one cycle after
// counter settles. Holding counter == cmd_count in DONE tells the planner the
// list is consumed; dropping plan_valid then returns the executor to IDLE.
module robo_cmd_executor
    import robo_pkg::*;
#(
    parameter int NODE_DEB = 1000,
    parameter int TURN_MIN = 2500000,
    parameter int TURN_MAX = 50000000
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic       plan_valid,
    input  logic [5:0] cmd_count,
    input  logic [2:0] robo_command,
    input  logic [2:0] line_sens,
    output logic [5:0] counter,
    output logic [1:0] mot_l,
    output logic [1:0] mot_r,
    output logic       busy,
    output logic       fault,
    output state_t     state
);

    localparam logic [TURN_TIMER_W-1:0] TURN_MIN_T = TURN_TIMER_W'(TURN_MIN);
    localparam logic [TURN_TIMER_W-1:0] TURN_MAX_T = TURN_TIMER_W'(TURN_MAX);

    logic                    node;
    logic [2:0]              cmd_q;
    logic [TURN_TIMER_W-1:0] turn_timer;
    logic [TURN_TIMER_W-1:0] timer_nxt;
    logic [5:0]              counter_nxt;
    logic                    centre_prev;
    logic                    reacq;        // U-turn: first centre edge seen
    logic                    centre;
    logic                    centre_rise;
    logic                    turn_armed;
    logic                    pivot_exit;

    node_detector #(.NODE_DEB(NODE_DEB)) u_node_det (
        .clk_50    (clk_50),
        .rst_n     (rst_n),
        .line_sens (line_sens),
        .node      (node)
    );

    assign centre      = line_sens[1];
    assign centre_rise = centre & ~centre_prev;
    assign timer_nxt   = turn_timer + TURN_TIMER_W'(1);
    assign counter_nxt = counter + 6'd1;
    assign turn_armed  = (turn_timer >= TURN_MIN_T);

    // Left/right leave on the first centre hit after the blind period. A
    // U-turn sweeps past the line once on the way round, so it leaves on the
    // second rising edge of centre after the blind period.
    always_comb begin
        pivot_exit = 1'b0;
        if (turn_armed && centre) begin
            if (cmd_q != CMD_UTURN) pivot_exit = 1'b1;
            else                    pivot_exit = centre_rise & reacq;
        end
    end

    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            counter     <= '0;
            mot_l       <= MOT_STOP;
            mot_r       <= MOT_STOP;
            busy        <= 1'b0;
            fault       <= 1'b0;
            cmd_q       <= CMD_NOP;
            turn_timer  <= '0;
            centre_prev <= 1'b0;
            reacq       <= 1'b0;
        end else begin
            centre_prev <= centre;
            case (state)
                ST_IDLE: begin
                    counter <= '0;
                    mot_l   <= MOT_STOP;
                    mot_r   <= MOT_STOP;
                    busy    <= 1'b0;
                    if (plan_valid && (cmd_count != 6'd0)) begin
                        state <= ST_FETCH;
                        busy  <= 1'b1;
                    end
                end

                ST_FETCH: begin
                    cmd_q      <= robo_command;
                    turn_timer <= '0;
                    reacq      <= 1'b0;
                    case (robo_command)
                        CMD_STRAIGHT: begin
                            state          <= ST_FOLLOW;
                            {mot_l, mot_r} <= follow_drive(line_sens);
                        end
                        CMD_LEFT: begin
                            state <= ST_PIVOT;
                            mot_l <= MOT_REV;
                            mot_r <= MOT_FWD;
                        end
                        CMD_RIGHT, CMD_UTURN: begin
                            state <= ST_PIVOT;
                            mot_l <= MOT_FWD;
                            mot_r <= MOT_REV;
                        end
                        default: state <= ST_NEXT;   // no-op and codes 5..7
                    endcase
                end

                ST_PIVOT: begin
                    turn_timer <= timer_nxt;
                    if (timer_nxt == TURN_MAX_T) begin
                        state <= ST_FAULT;
                        fault <= 1'b1;
                        busy  <= 1'b0;
                        mot_l <= MOT_STOP;
                        mot_r <= MOT_STOP;
                    end else if (pivot_exit) begin
                        state          <= ST_FOLLOW;
                        {mot_l, mot_r} <= follow_drive(line_sens);
                    end else if (turn_armed && centre_rise) begin
                        reacq <= 1'b1;
                    end
                end

                ST_FOLLOW: begin
                    {mot_l, mot_r} <= follow_drive(line_sens);
                    if (node) state <= ST_NEXT;
                end

                ST_NEXT: begin
                    counter <= counter_nxt;
                    if (counter_nxt == cmd_count) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        mot_l <= MOT_STOP;
                        mot_r <= MOT_STOP;
                    end else if (!plan_valid) begin
                        // Plan withdrawn: abandon the rest of the list.
                        state   <= ST_IDLE;
                        counter <= '0;
                        busy    <= 1'b0;
                        mot_l   <= MOT_STOP;
                        mot_r   <= MOT_STOP;
                    end else begin
                        state <= ST_FETCH;
                    end
                end

                ST_DONE: begin
                    mot_l <= MOT_STOP;
                    mot_r <= MOT_STOP;
                    busy  <= 1'b0;
                    if (!plan_valid) begin
                        state   <= ST_IDLE;
                        counter <= '0;
                    end
                end

                ST_FAULT: begin
                    mot_l <= MOT_STOP;
                    mot_r <= MOT_STOP;
                    busy  <= 1'b0;
                    fault <= 1'b1;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
